oric_sdram_bridge: RTL

//  Converts the Oric core's asynchronous-style byte RAM bus (ram_ad/ram_d/ram_cs/ram_oe/ram_we)

---
 rtl/oric_sdram_bridge_pkg.sv | 25 ++
 rtl/oric_sdram_bridge_if.sv | 25 ++
 rtl/oric_sdram_bridge_trigger.sv | 48 ++++
 rtl/oric_sdram_bridge.sv | 115 +++++++++++
 4 files changed

// File: rtl/oric_sdram_bridge_pkg.sv
// Shared definitions for the Oric RAM bus to SDRAM port1 bridge.
package oric_mem_pkg;

    typedef enum logic [0:0] {
        BR_IDLE,
        BR_WAIT_ACK
    } br_state_t;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_WORD = 2'b11;

    typedef struct packed {
        logic [15:0] ad;
        logic [7:0]  d;
        logic        we;
    } ram_req_t;

    // Writes strobe only the addressed byte lane; reads fetch the whole word.
    function automatic logic [1:0] req_ds(input ram_req_t r);
        if (!r.we) return DS_WORD;
        return r.ad[0] ? DS_HI : DS_LO;
    endfunction

endpackage

// File: rtl/oric_sdram_bridge_if.sv
// Core-side byte RAM bus and SDRAM-side toggle-handshake word port.
interface oric_ram_if;
    logic [15:0] ram_ad;
    logic [7:0]  ram_d;
    logic        ram_cs;
    logic        ram_oe;
    logic        ram_we;
    logic [7:0]  ram_q;

    modport master (output ram_ad, ram_d, ram_cs, ram_oe, ram_we, input ram_q);
    modport slave  (input ram_ad, ram_d, ram_cs, ram_oe, ram_we, output ram_q);
endinterface

interface oric_port_if #(parameter int ADDR_W = 24);
    logic              port_req;
    logic              port_ack;
    logic [ADDR_W-1:0] port_a;
    logic [1:0]        port_ds;
    logic              port_we;
    logic [15:0]       port_d;
    logic [15:0]       port_q;

    modport master (output port_req, port_a, port_ds, port_we, port_d, input port_ack, port_q);
    modport slave  (input port_req, port_a, port_ds, port_we, port_d, output port_ack, port_q);
endinterface

// File: rtl/oric_sdram_bridge_trigger.sv
// Samples the core bus and emits a one-clock trigger with the request sampled alongside it.
module oric_ram_trigger
    import oric_mem_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] i_ad,
    input  logic [7:0]  i_d,
    input  logic        i_cs,
    input  logic        i_oe,
    input  logic        i_we,
    output logic        o_trig,
    output ram_req_t    o_req
);

    logic        w_cs_oe;
    logic        w_cs_we;
    logic        r_cs_oe;
    logic        r_cs_we;
    logic [15:0] r_ad;
    logic        r_trig;
    ram_req_t    r_req;

    assign w_cs_oe = i_cs & i_oe;
    assign w_cs_we = i_cs & i_we;

    // Only reads retrigger on an address change; a held write needs a fresh we edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_cs_oe <= 1'b0;
            r_cs_we <= 1'b0;
            r_ad    <= '0;
            r_trig  <= 1'b0;
            r_req   <= '0;
        end else begin
            r_cs_oe <= w_cs_oe;
            r_cs_we <= w_cs_we;
            r_ad    <= i_ad;
            r_trig  <= (w_cs_oe & ~r_cs_oe) | (w_cs_we & ~r_cs_we) |
                       (w_cs_oe & (i_ad != r_ad));
            r_req   <= '{ad: i_ad, d: i_d, we: w_cs_we};
        end
    end

    assign o_trig = r_trig;
    assign o_req  = r_req;

endmodule

// File: rtl/oric_sdram_bridge.sv
// Bridge FSM: issues toggle requests to SDRAM port1 and returns the selected byte to the core.
module oric_sdram_bridge
    import oric_mem_pkg::*;
#(
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-16:0] BANK_BASE = '0
) (
    input  logic          clk_sys,
    input  logic          reset,
    oric_ram_if.slave     ram,
    oric_port_if.master   port,
    output logic          busy
);

    br_state_t r_state;
    br_state_t w_state_nxt;
    ram_req_t  r_lat;
    ram_req_t  r_pend;
    logic      r_pend_vld;
    logic      r_port_req;
    logic [7:0] r_ram_q;

    logic      w_trig;
    ram_req_t  w_trig_req;
    logic      w_ack;
    logic      w_issue;
    ram_req_t  w_issue_req;
    logic      w_pend_vld_nxt;
    ram_req_t  w_pend_nxt;
    logic      w_rd_done;

    oric_ram_trigger u_trigger (
        .clk_sys (clk_sys),
        .reset   (reset),
        .i_ad    (ram.ram_ad),
        .i_d     (ram.ram_d),
        .i_cs    (ram.ram_cs),
        .i_oe    (ram.ram_oe),
        .i_we    (ram.ram_we),
        .o_trig  (w_trig),
        .o_req   (w_trig_req)
    );

    assign w_ack = (r_state == BR_WAIT_ACK) && (port.port_ack == r_port_req);

    // A trigger arriving with the ack is newer than anything pending, so it replaces it.
    always_comb begin
        w_state_nxt    = r_state;
        w_issue        = 1'b0;
        w_issue_req    = w_trig_req;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_nxt     = r_pend;
        w_rd_done      = 1'b0;
        case (r_state)
            BR_IDLE: begin
                if (w_trig) begin
                    w_issue     = 1'b1;
                    w_state_nxt = BR_WAIT_ACK;
                end
            end
            BR_WAIT_ACK: begin
                if (w_ack) begin
                    w_rd_done = ~r_lat.we;
                    if (w_trig) begin
                        w_issue        = 1'b1;
                        w_pend_vld_nxt = 1'b0;
                    end else if (r_pend_vld) begin
                        w_issue        = 1'b1;
                        w_issue_req    = r_pend;
                        w_pend_vld_nxt = 1'b0;
                    end else begin
                        w_state_nxt = BR_IDLE;
                    end
                end else if (w_trig) begin
                    w_pend_vld_nxt = 1'b1;
                    w_pend_nxt     = w_trig_req;
                end
            end
            default: w_state_nxt = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= BR_IDLE;
            r_lat      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_port_req <= 1'b0;
            r_ram_q    <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            // NOTE: non-blocking, so the byte select below still sees the completing request's latch.
            if (w_rd_done)
                r_ram_q <= r_lat.ad[0] ? port.port_q[15:8] : port.port_q[7:0];
            if (w_issue) begin
                r_lat      <= w_issue_req;
                r_port_req <= ~r_port_req;
            end
        end
    end

    // Port outputs come straight from the latch, which only changes when a request is issued.
    assign port.port_req = r_port_req;
    assign port.port_a   = {BANK_BASE, r_lat.ad[15:1]};
    assign port.port_ds  = req_ds(r_lat);
    assign port.port_we  = r_lat.we;
    assign port.port_d   = {r_lat.d, r_lat.d};

    assign ram.ram_q = ram.ram_cs ? r_ram_q : 8'd0;
    assign busy      = (r_state != BR_IDLE);

endmodule
